// File: rtl/btn_conditioner.sv
// btn_conditioner: synchronise, debounce and latch pushbutton presses until the game tick consumes them,
// with optional auto-repeat while a button stays held.
module btn_conditioner #(
    parameter int N_BTN           = 3,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18,
    parameter int REPEAT_TICKS    = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    input  logic             tick,
    output logic [N_BTN-1:0] buttons,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] press_pulse
);
    typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;
    localparam int REP_W = REPEAT_TICKS > 0 ? $clog2(REPEAT_TICKS + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_TICKS > 0 ? REPEAT_TICKS - 1 : 0);

    logic [N_BTN-1:0] meta_q, sync_q;

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= btn_raw;
            sync_q <= meta_q;
        end

    genvar c;
    for (c = 0; c < N_BTN; c++) begin : g_ch
        state_t           state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic [REP_W-1:0] rep_q, rep_d;
        logic             pulse_q, pulse_d, level_q, level_d, req_q, req_d;
        logic             s, held, rep_fire;
        assign s = sync_q[c];

        always_comb begin
            state_d = state_q;
            cnt_d   = '0;
            pulse_d = 1'b0;
            unique case (state_q)
                IDLE:       state_d = s ? PRESS_WAIT : IDLE;
                PRESS_WAIT: begin
                    cnt_d = cnt_q + 1'b1;
                    if (!s) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (cnt_d == CNT_LAST) begin
                        state_d = HELD;
                        cnt_d   = '0;
                        pulse_d = 1'b1;
                    end
                end
                HELD:       state_d = s ? HELD : RELEASE_WAIT;
                RELEASE_WAIT: begin
                    cnt_d = cnt_q + 1'b1;
                    if (s) begin
                        state_d = HELD;
                        cnt_d   = '0;
                    end else if (cnt_d == CNT_LAST) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
                default:    state_d = IDLE;
            endcase
            held     = state_q == HELD || state_q == RELEASE_WAIT;
            // a repeat re-arms the request on the same tick that would otherwise clear it
            rep_fire = (REPEAT_TICKS > 0) && held && tick && rep_q == REP_LAST;
            rep_d    = (!held || rep_fire) ? '0 : (tick && rep_q != '1) ? rep_q + 1'b1 : rep_q;
            level_d  = state_d == HELD || state_d == RELEASE_WAIT;
            req_d    = pulse_q || rep_fire || (req_q && !tick);
        end

        always_ff @(posedge clk or negedge rst)
            if (!rst) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                rep_q   <= '0;
                pulse_q <= 1'b0;
                level_q <= 1'b0;
                req_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                rep_q   <= rep_d;
                pulse_q <= pulse_d;
                level_q <= level_d;
                req_q   <= req_d;
            end

        assign buttons[c]     = req_q;
        assign btn_level[c]   = level_q;
        assign press_pulse[c] = pulse_q;
    end
endmodule
